// File: rtl/lcd_line_writer.sv
// HD44780 8-bit two-row writer: power-up wait, fixed init command sequence, then
// continuous refresh of both rows from a snapshot of Line_1/Line_2 taken at each frame start.
module lcd_line_writer #(
    parameter int POWERUP_CYCLES    = 2000000,
    parameter int E_HIGH_CYCLES     = 50,
    parameter int CMD_WAIT_CYCLES   = 5000,
    parameter int CLEAR_WAIT_CYCLES = 200000
) (
    input  logic         Clock_100MHz,
    input  logic         Reset_n,
    input  logic [127:0] Line_1,
    input  logic [127:0] Line_2,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic         LCD_E,
    output logic [7:0]   LCD_Data,
    output logic         Init_done,
    output logic         Frame_done
);
    localparam int MAX_LONG   = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int MAX_SHORT  = (CMD_WAIT_CYCLES > E_HIGH_CYCLES) ? CMD_WAIT_CYCLES : E_HIGH_CYCLES;
    localparam int MAX_CYCLES = (MAX_LONG > MAX_SHORT) ? MAX_LONG : MAX_SHORT;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {POWER_WAIT, INIT, ADDR_1, WRITE_1, ADDR_2, WRITE_2} state_t;
    typedef enum logic [1:0] {SETUP, STROBE, HOLD, WAIT} phase_t;

    state_t           state, state_next;
    phase_t           phase, phase_next;
    logic [CNT_W-1:0] count, count_next, phase_end;
    logic [3:0]       col, col_next;
    logic [2:0]       init_idx, init_idx_next;
    logic [127:0]     snap_1, snap_2;
    logic             e_next, rs_next, init_done_next, frame_done_next;
    logic [7:0]       data_next;
    logic [6:0]       byte_base;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: init_cmd = 8'h38;
            3'd2:       init_cmd = 8'h0C;
            3'd3:       init_cmd = 8'h06;
            default:    init_cmd = 8'h01;
        endcase
    endfunction

    assign LCD_RW = 1'b0;

    always_comb begin
        state_next      = state;
        phase_next      = phase;
        count_next      = count + 1'b1;
        col_next        = col;
        init_idx_next   = init_idx;
        init_done_next  = Init_done;
        frame_done_next = 1'b0;

        case (phase)
            SETUP, HOLD: phase_end = CNT_W'(1);
            STROBE:      phase_end = CNT_W'(E_HIGH_CYCLES - 1);
            default:     phase_end = (state == INIT && init_idx == 3'd4) ?
                                     CNT_W'(CLEAR_WAIT_CYCLES - 1) : CNT_W'(CMD_WAIT_CYCLES - 1);
        endcase

        if (state == POWER_WAIT) begin
            if (count == CNT_W'(POWERUP_CYCLES - 1)) begin
                state_next    = INIT;
                phase_next    = SETUP;
                count_next    = '0;
                init_idx_next = 3'd0;
            end
        end else if (count == phase_end) begin
            count_next = '0;
            case (phase)
                SETUP:   phase_next = STROBE;
                STROBE:  phase_next = HOLD;
                HOLD:    phase_next = WAIT;
                default: begin
                    // End of a byte's post-wait: advance to the next byte with no idle cycle.
                    phase_next = SETUP;
                    case (state)
                        INIT: begin
                            if (init_idx == 3'd4) begin
                                state_next     = ADDR_1;
                                init_done_next = 1'b1;
                            end else begin
                                init_idx_next = init_idx + 3'd1;
                            end
                        end
                        ADDR_1:  state_next = WRITE_1;
                        WRITE_1: begin
                            col_next = col + 4'd1;
                            if (col == 4'd15) state_next = ADDR_2;
                        end
                        ADDR_2:  state_next = WRITE_2;
                        default: begin
                            col_next = col + 4'd1;
                            if (col == 4'd15) begin
                                state_next      = ADDR_1;
                                frame_done_next = 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end

        // Outputs are decoded from the next state so the pins are registered and glitch-free.
        e_next    = (phase_next == STROBE);
        rs_next   = 1'b0;
        data_next = 8'h00;
        byte_base = {4'd15 - col_next, 3'd0};
        case (state_next)
            INIT:    data_next = init_cmd(init_idx_next);
            ADDR_1:  data_next = 8'h80;
            WRITE_1: begin
                rs_next   = 1'b1;
                data_next = snap_1[byte_base +: 8];
            end
            ADDR_2:  data_next = 8'hC0;
            WRITE_2: begin
                rs_next   = 1'b1;
                data_next = snap_2[byte_base +: 8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock_100MHz) begin
        if (!Reset_n) begin
            state      <= POWER_WAIT;
            phase      <= SETUP;
            count      <= '0;
            col        <= '0;
            init_idx   <= '0;
            snap_1     <= {16{8'h20}};
            snap_2     <= {16{8'h20}};
            LCD_RS     <= 1'b0;
            LCD_E      <= 1'b0;
            LCD_Data   <= 8'h00;
            Init_done  <= 1'b0;
            Frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            phase      <= phase_next;
            count      <= count_next;
            col        <= col_next;
            init_idx   <= init_idx_next;
            LCD_RS     <= rs_next;
            LCD_E      <= e_next;
            LCD_Data   <= data_next;
            Init_done  <= init_done_next;
            Frame_done <= frame_done_next;
            if (state_next == ADDR_1 && state != ADDR_1) begin
                snap_1 <= Line_1;
                snap_2 <= Line_2;
            end
        end
    end
endmodule

// File: tb/tb_lcd_line_writer.sv
// Self-checking bench for lcd_line_writer: strobe-level capture compared against a
// frame model built from the row text present at the start of each frame.
module tb_lcd_line_writer;
    localparam int P         = 20;
    localparam int EH        = 3;
    localparam int CW        = 10;
    localparam int CLW       = 40;
    localparam int BYTE_CYC  = 4 + EH + CW;
    localparam int CLEAR_CYC = 4 + EH + CLW;
    localparam int FRAME_CYC = 34 * BYTE_CYC;

    typedef struct packed {
        logic       rs;
        logic [7:0] d;
    } strobe_t;

    logic         clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic [127:0] line_1 = '0;
    logic [127:0] line_2 = '0;
    logic         LCD_RS, LCD_RW, LCD_E, Init_done, Frame_done;
    logic [7:0]   LCD_Data;

    lcd_line_writer #(
        .POWERUP_CYCLES(P), .E_HIGH_CYCLES(EH),
        .CMD_WAIT_CYCLES(CW), .CLEAR_WAIT_CYCLES(CLW)
    ) dut (
        .Clock_100MHz(clk), .Reset_n(Reset_n), .Line_1(line_1), .Line_2(line_2),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_Data(LCD_Data),
        .Init_done(Init_done), .Frame_done(Frame_done)
    );

    always #5 clk = ~clk;

    int      cyc = 0;
    int      checks = 0;
    int      errors = 0;
    int      r_edge, t_clear, t_frame;
    strobe_t exp_q[$];

    int   fd_pulses = 0, fd_last = -1, fd_long = 0, id_rise = -1;
    logic fd_prev = 1'b0, id_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (Frame_done === 1'b1) begin
            fd_pulses++;
            fd_last = cyc;
            if (fd_prev) fd_long++;
        end
        if (Init_done === 1'b1 && !id_prev) id_rise = cyc;
        fd_prev = (Frame_done === 1'b1);
        id_prev = (Init_done === 1'b1);
    end

    function automatic logic [7:0] col_byte(input logic [127:0] l, input int c);
        logic [127:0] s;
        s = l >> (8 * (15 - c));
        return s[7:0];
    endfunction

    // A frame is: row-1 address, 16 row-1 chars, row-2 address, 16 row-2 chars.
    function automatic void push_frame(input logic [127:0] l1, input logic [127:0] l2);
        exp_q.push_back('{rs: 1'b0, d: 8'h80});
        for (int c = 0; c < 16; c++) exp_q.push_back('{rs: 1'b1, d: col_byte(l1, c)});
        exp_q.push_back('{rs: 1'b0, d: 8'hC0});
        for (int c = 0; c < 16; c++) exp_q.push_back('{rs: 1'b1, d: col_byte(l2, c)});
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Waits (bounded) for the next LCD_E rise, then measures the strobe through two cycles after its fall.
    task automatic capture_strobe(output logic [7:0] d, output logic rs, output int t_rise,
                                  output int hi_len, output bit stable, output bit ok);
        logic [7:0] h_d1, h_d2;
        logic       h_rs1, h_rs2, prev_e;
        int         n;
        h_d1 = 'x; h_d2 = 'x; h_rs1 = 'x; h_rs2 = 'x;
        prev_e = LCD_E;
        ok = 1'b0; stable = 1'b0; hi_len = 0; d = '0; rs = 1'b0; t_rise = -1; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (LCD_E === 1'b1 && prev_e !== 1'b1) begin
                ok     = 1'b1;
                d      = LCD_Data;
                rs     = LCD_RS;
                t_rise = cyc;
                stable = (h_d1 === d) && (h_d2 === d) && (h_rs1 === rs) && (h_rs2 === rs);
            end else begin
                h_d2 = h_d1; h_rs2 = h_rs1;
                h_d1 = LCD_Data; h_rs1 = LCD_RS;
            end
            prev_e = LCD_E;
        end
        if (ok) begin
            n = 0;
            while (LCD_E === 1'b1 && n < 200) begin
                if (LCD_Data !== d || LCD_RS !== rs) stable = 1'b0;
                hi_len++;
                @(negedge clk);
                n++;
            end
            if (LCD_Data !== d || LCD_RS !== rs) stable = 1'b0;
            @(negedge clk);
            if (LCD_Data !== d || LCD_RS !== rs || LCD_E !== 1'b0) stable = 1'b0;
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        line_1  = {"HELLO", {11{8'h20}}};
        line_2  = {16{8'h41}};
        repeat (3) @(negedge clk);
        checks++;
        if ({LCD_E, LCD_RS, LCD_RW, Init_done, Frame_done} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got E/RS/RW/Init/Frame=%b want 00000",
                     {LCD_E, LCD_RS, LCD_RW, Init_done, Frame_done});
        end
        checks++;
        if (LCD_Data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h want 00", LCD_Data);
        end
        Reset_n = 1'b1;
        r_edge  = cyc;
    endtask

    task automatic test_init();
        logic [7:0] d, cmds[5];
        logic       rs;
        int         t, hl, e_high;
        bit         st, ok;
        cmds = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
        e_high = 0;
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            if (LCD_E !== 1'b0) e_high++;
        end
        checks++;
        if (e_high != 0) begin
            errors++;
            $display("[TB] FAIL power_wait_quiet: got %0d E-high cycles want 0", e_high);
        end
        for (int i = 0; i < 5; i++) begin
            capture_strobe(d, rs, t, hl, st, ok);
            checks++;
            if (!ok || d !== cmds[i] || rs !== 1'b0) begin
                errors++;
                $display("[TB] FAIL init_byte%0d: got ok=%0d rs=%b data=%h want rs=0 data=%h",
                         i, ok, rs, d, cmds[i]);
            end
            checks++;
            if (t != r_edge + P + 2 + i * BYTE_CYC) begin
                errors++;
                $display("[TB] FAIL init_time%0d: got cycle %0d want %0d", i, t, r_edge + P + 2 + i * BYTE_CYC);
            end
            if (i == 4) t_clear = t;
        end
        checks++;
        if (Init_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL init_done_early: got %b want 0", Init_done);
        end
    endtask

    task automatic test_frame();
        logic [7:0] d;
        logic       rs;
        int         t, hl, t0, fd_before;
        bit         st, ok;
        strobe_t    e;
        fd_before = fd_pulses;
        exp_q.delete();
        push_frame(line_1, line_2);
        for (int i = 0; i < 34; i++) begin
            capture_strobe(d, rs, t, hl, st, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || d !== e.d || rs !== e.rs) begin
                errors++;
                $display("[TB] FAIL frame_byte%0d: got rs=%b data=%h want rs=%b data=%h", i, rs, d, e.rs, e.d);
            end
            if (i == 0) begin
                t0 = t;
                checks++;
                if (t != t_clear + CLEAR_CYC) begin
                    errors++;
                    $display("[TB] FAIL clear_wait: got cycle %0d want %0d", t, t_clear + CLEAR_CYC);
                end
            end
        end
        checks++;
        if (id_rise != t0 - 2 || Init_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL init_done_rise: got cycle %0d level %b want %0d level 1", id_rise, Init_done, t0 - 2);
        end
        capture_strobe(d, rs, t, hl, st, ok);
        checks++;
        if (!ok || d !== 8'h80 || t != t0 + FRAME_CYC) begin
            errors++;
            $display("[TB] FAIL next_frame_start: got data=%h cycle %0d want 80 at %0d", d, t, t0 + FRAME_CYC);
        end
        checks++;
        if (fd_pulses - fd_before != 1 || fd_last != t - 2 || fd_long != 0) begin
            errors++;
            $display("[TB] FAIL frame_done_pulse: got %0d pulses last %0d long %0d want 1 at %0d long 0",
                     fd_pulses - fd_before, fd_last, fd_long, t - 2);
        end
        t_frame = t;
    endtask

    task automatic test_snapshot();
        logic [7:0] d;
        logic       rs;
        int         t, hl;
        bit         st, ok;
        strobe_t    e;
        exp_q.delete();
        push_frame(line_1, line_2);
        void'(exp_q.pop_front());
        for (int i = 0; i < 33; i++) begin
            capture_strobe(d, rs, t, hl, st, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || d !== e.d || rs !== e.rs) begin
                errors++;
                $display("[TB] FAIL snap_old_byte%0d: got rs=%b data=%h want rs=%b data=%h", i + 1, rs, d, e.rs, e.d);
            end
            if (i == 5) line_1 = {16{8'h42}};
        end
        push_frame(line_1, line_2);
        for (int i = 0; i < 34; i++) begin
            capture_strobe(d, rs, t, hl, st, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || d !== e.d || rs !== e.rs) begin
                errors++;
                $display("[TB] FAIL snap_new_byte%0d: got rs=%b data=%h want rs=%b data=%h", i, rs, d, e.rs, e.d);
            end
            if (i == 0) begin
                checks++;
                if (t != t_frame + FRAME_CYC) begin
                    errors++;
                    $display("[TB] FAIL snap_frame_period: got cycle %0d want %0d", t, t_frame + FRAME_CYC);
                end
                t_frame = t;
            end
        end
    endtask

    task automatic test_timing();
        logic [7:0] d;
        logic       rs;
        int         t, hl, t_exp;
        bit         st, ok;
        strobe_t    e;
        exp_q.delete();
        push_frame(line_1, line_2);
        t_exp = t_frame + FRAME_CYC;
        for (int i = 0; i < 34; i++) begin
            capture_strobe(d, rs, t, hl, st, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || d !== e.d || rs !== e.rs || t != t_exp) begin
                errors++;
                $display("[TB] FAIL timing_byte%0d: got data=%h rs=%b cycle %0d want data=%h rs=%b cycle %0d",
                         i, d, rs, t, e.d, e.rs, t_exp);
            end
            checks++;
            if (hl != EH || !st) begin
                errors++;
                $display("[TB] FAIL strobe_shape%0d: got E-high %0d stable %0d want %0d stable 1", i, hl, st, EH);
            end
            if (i == 0) t_frame = t;
            t_exp = t + BYTE_CYC;
        end
    endtask

    task automatic test_random_refresh();
        logic [7:0] d;
        logic       rs;
        int         t, hl, k;
        bit         st, ok;
        strobe_t    e;
        for (int f = 0; f < 4; f++) begin
            exp_q.delete();
            push_frame(line_1, line_2);
            k = (f < 3) ? int'($urandom_range(1, 33)) : -1;
            for (int i = 0; i < 34; i++) begin
                capture_strobe(d, rs, t, hl, st, ok);
                e = exp_q.pop_front();
                checks++;
                if (!ok || d !== e.d || rs !== e.rs) begin
                    errors++;
                    $display("[TB] FAIL rand_f%0d_byte%0d: got rs=%b data=%h want rs=%b data=%h",
                             f, i, rs, d, e.rs, e.d);
                end
                if (i == 0) begin
                    checks++;
                    if (t != t_frame + FRAME_CYC) begin
                        errors++;
                        $display("[TB] FAIL rand_period%0d: got cycle %0d want %0d", f, t, t_frame + FRAME_CYC);
                    end
                    t_frame = t;
                end
                if (i == k) begin
                    line_1 = rand_line();
                    line_2 = rand_line();
                end
            end
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] d;
        logic       rs;
        int         t, hl, n;
        bit         st, ok;
        for (int i = 0; i < 21; i++) capture_strobe(d, rs, t, hl, st, ok);
        n = 0;
        while (LCD_E !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (LCD_E !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write2_strobe_seen: got E=%b want 1", LCD_E);
        end
        Reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({LCD_E, Init_done, Frame_done, LCD_RS} !== 4'b0 || LCD_Data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midbyte_reset: got E/Init/Frame/RS=%b data=%h want 0000 data=00",
                     {LCD_E, Init_done, Frame_done, LCD_RS}, LCD_Data);
        end
        Reset_n = 1'b1;
        r_edge  = cyc;
        test_init();
        capture_strobe(d, rs, t, hl, st, ok);
        checks++;
        if (!ok || d !== 8'h80 || t != t_clear + CLEAR_CYC || id_rise != t - 2) begin
            errors++;
            $display("[TB] FAIL reinit_first_frame: got data=%h cycle %0d init_rise %0d want 80 at %0d rise %0d",
                     d, t, id_rise, t_clear + CLEAR_CYC, t_clear + CLEAR_CYC - 2);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got no end of test want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_init();
        test_frame();
        test_snapshot();
        test_timing();
        test_random_refresh();
        test_reset_mid_byte();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
